// File: rtl/merge_rr_5to1.sv
// Five-input round-robin burst merger feeding a 2-entry output FIFO.
// Optional MERGE_HDR_EN: prefix every burst with header word 32'hC0DE_0000 | port.
module merge_rr_5to1 #(
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 16,
  parameter int BURST_CNT_W = 5
) (
  input  logic              clk_user,
  input  logic              reset,
  input  logic [DATA_W-1:0] dout_leaf_interface2user_1,
  input  logic [DATA_W-1:0] dout_leaf_interface2user_2,
  input  logic [DATA_W-1:0] dout_leaf_interface2user_3,
  input  logic [DATA_W-1:0] dout_leaf_interface2user_4,
  input  logic [DATA_W-1:0] dout_leaf_interface2user_5,
  input  logic              vld_interface2user_1,
  input  logic              vld_interface2user_2,
  input  logic              vld_interface2user_3,
  input  logic              vld_interface2user_4,
  input  logic              vld_interface2user_5,
  output logic              ack_user2interface_1,
  output logic              ack_user2interface_2,
  output logic              ack_user2interface_3,
  output logic              ack_user2interface_4,
  output logic              ack_user2interface_5,
  output logic [DATA_W-1:0] din_leaf_user2interface_1,
  output logic              vld_user2interface_1,
  input  logic              ack_interface2user_1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t                 state;
  logic [2:0]             ptr;
  logic [2:0]             grant;
  logic [BURST_CNT_W-1:0] beats;

  logic [DATA_W-1:0]      fifo_mem [2];
  logic                   rd_idx;
  logic [1:0]             count;

  logic [4:0]             in_vld;
  logic [DATA_W-1:0]      in_data [5];
  logic [4:0]             ack_vec;
  logic [3:0]             pick;
  logic                   fifo_room;
  logic                   gnt_vld;
  logic [DATA_W-1:0]      gnt_data;
  logic                   xfer_acc;
  logic                   hdr_push;
  logic                   push;
  logic                   pop;
  logic [DATA_W-1:0]      push_data;
  logic [DATA_W-1:0]      hdr_word;
  logic                   burst_last;

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p == 3'd5) ? 3'd1 : p + 3'd1;
  endfunction

  // Returns {found, port}: first requesting port strictly after 'from', wrapping 5->1.
  function automatic logic [3:0] rr_pick(input logic [2:0] from, input logic [4:0] req);
    logic [2:0] p;
    logic [3:0] r;
    r = '0;
    p = from;
    for (int i = 0; i < 5; i++) begin
      p = next_port(p);
      if (!r[3] && req[p - 3'd1]) r = {1'b1, p};
    end
    return r;
  endfunction

  assign in_vld = {vld_interface2user_5, vld_interface2user_4, vld_interface2user_3,
                   vld_interface2user_2, vld_interface2user_1};
  assign in_data[0] = dout_leaf_interface2user_1;
  assign in_data[1] = dout_leaf_interface2user_2;
  assign in_data[2] = dout_leaf_interface2user_3;
  assign in_data[3] = dout_leaf_interface2user_4;
  assign in_data[4] = dout_leaf_interface2user_5;

  assign pick       = rr_pick(ptr, in_vld);
  assign fifo_room  = (count != 2'd2);
  assign gnt_vld    = in_vld[grant - 3'd1];
  assign gnt_data   = in_data[grant - 3'd1];
  assign xfer_acc   = (state == XFER) && fifo_room && gnt_vld;
  assign burst_last = (beats == BURST_CNT_W'(BURST_LEN - 1));
  assign hdr_word   = DATA_W'(32'hC0DE_0000 | {29'd0, grant});

`ifdef MERGE_HDR_EN
  localparam state_t GRANT_STATE = HDR;
  assign hdr_push = (state == HDR) && fifo_room;
`else
  localparam state_t GRANT_STATE = XFER;
  assign hdr_push = 1'b0;
`endif

  assign push      = xfer_acc || hdr_push;
  assign push_data = hdr_push ? hdr_word : gnt_data;
  assign pop       = vld_user2interface_1 && ack_interface2user_1;

  // Accept depends on registered state and count only, never on downstream ack.
  always_comb begin
    ack_vec = '0;
    if ((state == XFER) && fifo_room) ack_vec[grant - 3'd1] = 1'b1;
  end

  assign ack_user2interface_1 = ack_vec[0];
  assign ack_user2interface_2 = ack_vec[1];
  assign ack_user2interface_3 = ack_vec[2];
  assign ack_user2interface_4 = ack_vec[3];
  assign ack_user2interface_5 = ack_vec[4];

  assign vld_user2interface_1      = (count != 2'd0);
  assign din_leaf_user2interface_1 = vld_user2interface_1 ? fifo_mem[rd_idx] : '0;

  // FIFO storage is data only; emptiness masks stale contents on the output.
  always_ff @(posedge clk_user) begin
    if (push) fifo_mem[rd_idx ^ count[0]] <= push_data;
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      count  <= 2'd0;
      rd_idx <= 1'b0;
    end else begin
      if (pop) rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 3'd5;
      grant <= 3'd1;
      beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick[3]) begin
            grant <= pick[2:0];
            beats <= '0;
            state <= GRANT_STATE;
          end
        end
        HDR: begin
          if (fifo_room) state <= XFER;
        end
        XFER: begin
          // A full FIFO stalls the burst; only a gap or the final beat ends it.
          if (fifo_room) begin
            if (gnt_vld) begin
              beats <= beats + BURST_CNT_W'(1);
              if (burst_last) begin
                state <= IDLE;
                ptr   <= grant;
              end
            end else begin
              state <= IDLE;
              ptr   <= grant;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
